tri_digit_scan: RTL and testbench
=================================

# tri_digit_scan

Three-digit BCD event counter with multiplexed seven-segment output, placed directly downstream of the mod-3 mode counter. Consumes the counter's 2-bit scan code (sequence 00 → 10 → 01 → 00) as the digit-select phase. Drives one digit's segments and its anode enable per cycle, and keeps a 000–999 count that advances on a tick input.

## Interface
Parameters:
- LZB, default 1: leading-zero blanking enable (1 = blank leading zeros of hundreds and tens).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- scan  input  2  digit-select code from the mode counter (00 units, 10 tens, 01 hundreds, 11 illegal)
- tick  input  1  count-enable pulse; one increment per cycle it is high
- hold  input  1  freezes the count; display keeps scanning
- clr  input  1  synchronous clear of the count to 000
- seg  output  7  segments, active-high, seg[6]=a … seg[0]=g
- an  output  3  digit enables, active-high, an[0]=units, an[1]=tens, an[2]=hundreds
- value  output  12  current count, BCD, {hundreds, tens, units}
- ovf  output  1  one-cycle pulse on wrap 999 → 000
- err  output  1  high while registered scan phase is illegal (11)

## Operation
- Reset (rst=0, asynchronous): value=000, seg=0000000, an=000, ovf=0, err=0.
- Count priority per edge: clr > hold > tick.
  - clr=1: value←000, ovf←0.
  - clr=0, hold=1: value unchanged.
  - clr=0, hold=0, tick=1: BCD increment. Units 9→0 carries into tens; tens 9→0 carries into hundreds; 999→000 sets ovf for that cycle only.
  - Otherwise value unchanged.
- Digit values never exceed 9. Each digit is a 4-bit BCD counter with carry-out at 9.
- Scan decode, registered:
  - 00 → an=001, seg=font(units)
  - 10 → an=010, seg=font(tens)
  - 01 → an=100, seg=font(hundreds)
  - 11 → an=000, seg=0000000, err=1
- Font table, active-high, abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Leading-zero blanking (LZB=1):
  - Hundreds blank when hundreds=0.
  - Tens blank when hundreds=0 and tens=0.
  - Units never blank.
  - A blanked digit keeps its an bit asserted with seg=0000000.
- Display uses the value registered before the current edge, not the value being written on that edge.

## Timing
- seg/an/err: 1-cycle latency from scan. Sampled scan at edge N appears after edge N.
- value: updates at the edge where tick/clr is sampled.
- ovf: high for exactly the one cycle in which value=000 after the wrap. A tick in that same cycle clears ovf and moves value to 001.
- Simultaneous clr and tick at 999: value←000, ovf stays 0.
- hold=1 with tick=1 at 999: no wrap, ovf=0.
- Illegal scan 11 mid-run: count unaffected; display resumes normally on the next legal code.
- Reset asserted mid-count: all outputs go to reset values immediately, independent of clk. After release, count restarts at 000 on the first tick.

## Structure
- Shared package holds:
  - scan code constants SCAN_U=2'b00, SCAN_T=2'b10, SCAN_H=2'b01
  - SEG_BLANK=7'b0000000
  - the ten font constants
- Sub-module bcd_to_seg7: 4-bit BCD plus blank input → 7-bit segments, purely combinational. Inputs 10–15 map to SEG_BLANK.
- Top contains the three chained BCD digit counters, the blanking logic, the scan mux and the output registers.

## Test plan
- Reset then scan cycling 00,10,01 with no tick → an=001,010,100 in turn; seg=1111110 on units and blank on tens/hundreds (LZB=1); value=000.
- 12 ticks → value=012; scan 10 gives seg=0110000, scan 01 gives seg=0000000, scan 00 gives seg=1101101.
- Preload to 999 via 999 ticks, then one tick → value=000, ovf=1 for one cycle, then 0.
- At 998, tick with hold=1 for 5 cycles → value stays 998; clr=1 together with tick → value=000, ovf=0.
- Drive scan=11 → next cycle an=000, seg=0000000, err=1; return to 00 → err=0, an=001.
- Assert rst low between clock edges at value=457 → seg, an, value, ovf and err are 0 before the next edge.

Source files
------------

// File: rtl/tri_digit_scan_pkg.sv
// Shared constants for the three-digit scanned BCD display: scan codes,
// seven-segment font (active-high, abcdefg) and the BCD digit increment helper.
package tri_digit_scan_pkg;

  localparam logic [1:0] SCAN_U = 2'b00;
  localparam logic [1:0] SCAN_T = 2'b10;
  localparam logic [1:0] SCAN_H = 2'b01;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] FONT_0    = 7'b1111110;
  localparam logic [6:0] FONT_1    = 7'b0110000;
  localparam logic [6:0] FONT_2    = 7'b1101101;
  localparam logic [6:0] FONT_3    = 7'b1111001;
  localparam logic [6:0] FONT_4    = 7'b0110011;
  localparam logic [6:0] FONT_5    = 7'b1011011;
  localparam logic [6:0] FONT_6    = 7'b1011111;
  localparam logic [6:0] FONT_7    = 7'b1110000;
  localparam logic [6:0] FONT_8    = 7'b1111111;
  localparam logic [6:0] FONT_9    = 7'b1111011;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Returns {carry_out, next_digit}; a digit at 9 (or corrupt >9) wraps to 0 with carry.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic cin);
    logic [4:0] r;
    r = {1'b0, d};
    if (cin) begin
      if (d >= BCD_MAX) r = {1'b1, 4'd0};
      else              r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/tri_digit_scan_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder with a blank override.
// Codes 10-15 decode to all segments off.
module bcd_to_seg7
  import tri_digit_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = FONT_0;
        4'd1:    seg_o = FONT_1;
        4'd2:    seg_o = FONT_2;
        4'd3:    seg_o = FONT_3;
        4'd4:    seg_o = FONT_4;
        4'd5:    seg_o = FONT_5;
        4'd6:    seg_o = FONT_6;
        4'd7:    seg_o = FONT_7;
        4'd8:    seg_o = FONT_8;
        4'd9:    seg_o = FONT_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/tri_digit_scan.sv
// Three-digit BCD event counter (000-999) with a registered, scan-code driven
// multiplexed seven-segment output and optional leading-zero blanking.
module tri_digit_scan
  import tri_digit_scan_pkg::*;
#(
  parameter logic LZB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  scan,
  input  logic        tick,
  input  logic        hold,
  input  logic        clr,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] value,
  output logic        ovf,
  output logic        err
);

  logic [3:0] units_q, units_d;
  logic [3:0] tens_q,  tens_d;
  logic [3:0] hund_q,  hund_d;
  logic       ovf_q,   ovf_d;
  logic [6:0] seg_q,   seg_d;
  logic [2:0] an_q,    an_d;
  logic       err_q,   err_d;

  logic [4:0] units_inc, tens_inc, hund_inc;
  logic [3:0] digit_sel;
  logic       blank_sel;

  // Ripple carry through the three digits; hundreds carry-out marks the 999 wrap.
  assign units_inc = bcd_inc(units_q, 1'b1);
  assign tens_inc  = bcd_inc(tens_q,  units_inc[4]);
  assign hund_inc  = bcd_inc(hund_q,  tens_inc[4]);

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    ovf_d   = 1'b0;
    if (clr) begin
      units_d = 4'd0;
      tens_d  = 4'd0;
      hund_d  = 4'd0;
    end else if (!hold && tick) begin
      units_d = units_inc[3:0];
      tens_d  = tens_inc[3:0];
      hund_d  = hund_inc[3:0];
      ovf_d   = hund_inc[4];
    end
  end

  // Display reads the count as it stood before this edge.
  always_comb begin
    digit_sel = units_q;
    blank_sel = 1'b0;
    an_d      = 3'b000;
    err_d     = 1'b0;
    case (scan)
      SCAN_U: begin
        digit_sel = units_q;
        an_d      = 3'b001;
      end
      SCAN_T: begin
        digit_sel = tens_q;
        blank_sel = LZB && (hund_q == 4'd0) && (tens_q == 4'd0);
        an_d      = 3'b010;
      end
      SCAN_H: begin
        digit_sel = hund_q;
        blank_sel = LZB && (hund_q == 4'd0);
        an_d      = 3'b100;
      end
      default: begin
        blank_sel = 1'b1;
        err_d     = 1'b1;
      end
    endcase
  end

  bcd_to_seg7 u_font (
    .bcd_i   (digit_sel),
    .blank_i (blank_sel),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      ovf_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      err_q   <= err_d;
    end
  end

  assign value = {hund_q, tens_q, units_q};
  assign ovf   = ovf_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign err   = err_q;

endmodule

// File: tb/tb_tri_digit_scan.sv
// Bench for tri_digit_scan: directed steps plus random traffic, every cycle
// checked against an integer-count reference model.
module tb_tri_digit_scan;

  localparam logic LZB = 1'b1;

  logic        clk;
  logic        rst;
  logic [1:0]  scan;
  logic        tick, hold, clr;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] value;
  logic        ovf, err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: count as a plain integer 0..999.
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic [6:0] m_seg = 7'b0;
  logic [2:0] m_an  = 3'b0;
  logic       m_err = 1'b0;

  logic [6:0] font [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011};

  tri_digit_scan #(.LZB(LZB)) dut (
    .clk   (clk),
    .rst   (rst),
    .scan  (scan),
    .tick  (tick),
    .hold  (hold),
    .clr   (clr),
    .seg   (seg),
    .an    (an),
    .value (value),
    .ovf   (ovf),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int c);
    logic [3:0] h, t, u;
    h = 4'((c / 100) % 10);
    t = 4'((c / 10) % 10);
    u = 4'(c % 10);
    return {h, t, u};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".value"}, value, to_bcd(m_cnt));
    chk({tag, ".ovf"},   {11'd0, ovf}, {11'd0, m_ovf});
    chk({tag, ".seg"},   {5'd0, seg},  {5'd0, m_seg});
    chk({tag, ".an"},    {9'd0, an},   {9'd0, m_an});
    chk({tag, ".err"},   {11'd0, err}, {11'd0, m_err});
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic [1:0] sc, input logic tk, input logic hd,
                      input logic cl, input string tag);
    int h, t, u;
    scan = sc; tick = tk; hold = hd; clr = cl;
    @(posedge clk);
    #1;
    h = m_cnt / 100;
    t = (m_cnt / 10) % 10;
    u = m_cnt % 10;
    m_err = 1'b0;
    case (sc)
      2'b00: begin m_an = 3'b001; m_seg = font[u]; end
      2'b10: begin m_an = 3'b010; m_seg = (LZB && h == 0 && t == 0) ? 7'b0 : font[t]; end
      2'b01: begin m_an = 3'b100; m_seg = (LZB && h == 0) ? 7'b0 : font[h]; end
      default: begin m_an = 3'b000; m_seg = 7'b0; m_err = 1'b1; end
    endcase
    m_ovf = 1'b0;
    if (cl) m_cnt = 0;
    else if (!hd && tk) begin
      if (m_cnt == 999) begin
        m_cnt = 0;
        m_ovf = 1'b1;
      end else m_cnt = m_cnt + 1;
    end
    check_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic [1:0] sc;
      sc = 2'($urandom_range(0, 2));
      if (sc == 2'd1) sc = 2'b10;
      else if (sc == 2'd2) sc = 2'b01;
      step(sc, 1'b1, 1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    rst = 1'b0; scan = 2'b00; tick = 1'b0; hold = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 rst = 1'b1;

    step(2'b00, 1'b0, 1'b0, 1'b0, "idle_u");
    chk("idle_u.seg_const", {5'd0, seg}, {5'd0, 7'b1111110});
    step(2'b10, 1'b0, 1'b0, 1'b0, "idle_t");
    chk("idle_t.an_const", {9'd0, an}, 12'h002);
    step(2'b01, 1'b0, 1'b0, 1'b0, "idle_h");
    chk("idle_h.an_const", {9'd0, an}, 12'h004);

    ticks(12, "tick12");
    chk("tick12.value_const", value, 12'h012);
    step(2'b10, 1'b0, 1'b0, 1'b0, "d012_t");
    chk("d012_t.seg_const", {5'd0, seg}, {5'd0, 7'b0110000});
    step(2'b01, 1'b0, 1'b0, 1'b0, "d012_h");
    chk("d012_h.seg_const", {5'd0, seg}, 12'h000);
    step(2'b00, 1'b0, 1'b0, 1'b0, "d012_u");
    chk("d012_u.seg_const", {5'd0, seg}, {5'd0, 7'b1101101});

    ticks(987, "to999");
    chk("to999.value_const", value, 12'h999);
    step(2'b01, 1'b1, 1'b0, 1'b0, "wrap");
    chk("wrap.ovf_const", {11'd0, ovf}, 12'h001);
    step(2'b00, 1'b0, 1'b0, 1'b0, "after_wrap");
    chk("after_wrap.ovf_const", {11'd0, ovf}, 12'h000);

    ticks(998, "to998");
    for (int i = 0; i < 5; i++) step(2'b00, 1'b1, 1'b1, 1'b0, "hold998");
    chk("hold998.value_const", value, 12'h998);
    step(2'b00, 1'b1, 1'b0, 1'b1, "clr_tick");
    chk("clr_tick.value_const", value, 12'h000);

    ticks(999, "again999");
    step(2'b00, 1'b1, 1'b1, 1'b0, "hold_at999");
    chk("hold_at999.ovf_const", {11'd0, ovf}, 12'h000);
    step(2'b10, 1'b1, 1'b0, 1'b1, "clr_at999");
    chk("clr_at999.ovf_const", {11'd0, ovf}, 12'h000);

    ticks(5, "pre_illegal");
    step(2'b11, 1'b1, 1'b0, 1'b0, "illegal");
    chk("illegal.err_const", {11'd0, err}, 12'h001);
    step(2'b00, 1'b0, 1'b0, 1'b0, "legal_again");
    chk("legal_again.an_const", {9'd0, an}, 12'h001);

    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0), "random");
    end

    step(2'b00, 1'b0, 1'b0, 1'b1, "clr457");
    ticks(457, "to457");
    chk("to457.value_const", value, 12'h457);
    #2 rst = 1'b0;
    #1;
    m_cnt = 0; m_ovf = 1'b0; m_seg = 7'b0; m_an = 3'b0; m_err = 1'b0;
    check_all("async_rst");
    #1 rst = 1'b1;
    step(2'b00, 1'b1, 1'b0, 1'b0, "restart");
    chk("restart.value_const", value, 12'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
